bsg_cam_1r1w_alloc_ctrl: RTL
============================

BSG_CAM_1R1W_ALLOC_CTRL -- requirements
Module: bsg_cam_1r1w_alloc_ctrl

Interface
REQ-001 The block SHALL have parameter els_p, default 4: number of CAM entries.
REQ-002 The block SHALL have parameter tag_width_p, default 8: tag width.
REQ-003 The block SHALL have parameter data_width_p, default 16: data width.
REQ-004 The block SHALL have port clk  input  1  clock.
REQ-005 The block SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_v_i / req_ready_o  in/out  1  request valid/ready.
REQ-007 The block SHALL have port req_op_i  input  2  operation: 0 LOOKUP, 1 INSERT, 2 INVALIDATE, 3 reserved.
REQ-008 The block SHALL have port req_tag_i / req_data_i  input  tag_width_p / data_width_p  request tag / data.
REQ-009 The block SHALL have port resp_v_o / resp_yumi_i  out/in  1  lookup response valid/consume.
REQ-010 The block SHALL have port resp_hit_o / resp_data_o  output  1 / data_width_p  lookup hit / data.
REQ-011 The block SHALL have port evict_v_o / evict_tag_o  output  1 / tag_width_p  replaced-entry pulse / tag.
REQ-012 The block SHALL have port cam_w_v_o  output  els_p  one-hot write select to the CAM.
REQ-013 The block SHALL have ports cam_w_set_not_clear_o, cam_w_tag_o, cam_w_data_o  output  1 / tag_width_p / data_width_p  CAM write controls.
REQ-014 The block SHALL have port cam_w_empty_i  input  els_p  CAM per-entry empty flags.
REQ-015 The block SHALL have ports cam_r_v_o / cam_r_tag_o  output  1 / tag_width_p  CAM read request.
REQ-016 The block SHALL have ports cam_r_v_i / cam_r_data_i  input  1 / data_width_p  CAM read result, valid one cycle after cam_r_v_o.

Function
REQ-017 FSM states SHALL be IDLE, RD and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-018 Shadow state SHALL be a per-entry valid bit and tag, plus a round-robin pointer rr (lg els_p bits).
REQ-019 An accepted LOOKUP (cycle N) SHALL drive cam_r_v_o=1 and cam_r_tag_o=req_tag_i in cycle N, then IDLE->RD.
REQ-020 In RD, the block SHALL capture cam_r_v_i into resp_hit_o and cam_r_data_i into resp_data_o, then RD->RESP.
REQ-021 resp_v_o SHALL be 1 in RESP, first asserted in cycle N+2, with resp fields held stable until resp_yumi_i; RESP->IDLE on resp_yumi_i.
REQ-022 An accepted INSERT SHALL write in the same cycle with cam_w_set_not_clear_o=1 and SHALL stay in IDLE.
REQ-023 INSERT target selection SHALL be: shadow tag hit -> that entry (data update, no evict); else lowest-index set bit of cam_w_empty_i; else entry rr.
REQ-024 An INSERT to entry rr while all entries are full SHALL pulse evict_v_o for one cycle with the old tag on evict_tag_o and SHALL advance rr = (rr+1) mod els_p.
REQ-025 An accepted INVALIDATE with a shadow hit SHALL drive a one-hot cam_w_v_o with cam_w_set_not_clear_o=0 and clear the shadow valid bit; a miss SHALL issue no write.
REQ-026 Op 3 SHALL be accepted with no effect.
REQ-027 cam_w_v_o SHALL be 0 whenever no write occurs; cam_w_tag_o/cam_w_data_o SHALL equal req_tag_i/req_data_i (never X).
REQ-028 A write at edge N SHALL be visible to a LOOKUP accepted in cycle N+1 or later, with no stall inserted.
REQ-029 Shadow valid SHALL equal ~cam_w_empty_i at every rising clock edge outside reset.

Reset
REQ-030 While reset=0 the block SHALL hold state IDLE, shadow valid 0, rr 0, and all outputs 0.
REQ-031 Reset asserted in RD or RESP SHALL discard the pending response; no resp_v_o SHALL be asserted after release.
REQ-032 The first request SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-033 The op encoding and FSM state enum SHALL be in package bsg_cam_1r1w_alloc_pkg.
REQ-034 Target/victim selection (priority pick plus rr pointer) SHALL be sub-module bsg_cam_1r1w_alloc_victim.
REQ-035 The bench SHALL connect the block to bsg_cam_1r1w_sync_unmanaged with matching parameters and a shared clk/reset.

Verification
REQ-036 After reset, INSERT 0x00/0xdead then INSERT 0x11/0xbeef -> cam_w_v_o = 0001 then 0010; cam_w_empty_i = 1100.
REQ-037 LOOKUP 0x11 -> resp_v_o at N+2 with hit=1, data=0xbeef; hold resp_yumi_i=0 for 3 cycles -> data stable and req_ready_o=0.
REQ-038 Fill 4 entries, then INSERT 0x44 -> entry 0 written, evict_v_o=1 with evict_tag_o=0x00, rr=1; the next new tag goes to entry 1.
REQ-039 INSERT 0x11/0x1234 with 0x11 present -> same entry rewritten, no evict; LOOKUP 0x11 -> 0x1234.
REQ-040 INVALIDATE 0x00 then LOOKUP 0x00 -> hit=0 and cam_w_empty_i bit 0 set; INVALIDATE of an absent tag -> cam_w_v_o=0.
REQ-041 Assert reset during RD -> no response after release, req_ready_o=1, all entries empty.

Source files
------------

// File: rtl/bsg_cam_1r1w_alloc_pkg.sv
// Shared definitions for the CAM allocation controller: request opcodes and FSM states.
package bsg_cam_1r1w_alloc_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP     = 2'd0,
        OP_INSERT     = 2'd1,
        OP_INVALIDATE = 2'd2,
        OP_RESERVED   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/bsg_cam_1r1w_alloc_victim.sv
// Insert target selection: lowest-index empty entry, or the round-robin victim once the CAM is full.
module bsg_cam_1r1w_alloc_victim
    import bsg_cam_1r1w_alloc_pkg::*;
#(
    parameter int els_p    = 4,
    parameter int lg_els_p = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [els_p-1:0]    empty,
    input  logic                advance,
    output logic [els_p-1:0]    target,
    output logic                full,
    output logic [lg_els_p-1:0] rr
);

    logic [lg_els_p-1:0] rr_reg;
    logic [els_p-1:0]    empty_pick;
    logic [els_p-1:0]    rr_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < els_p; gi++) begin : g_pick
            if (gi == 0) begin : g_first
                assign empty_pick[gi] = empty[gi];
            end else begin : g_rest
                assign empty_pick[gi] = empty[gi] & ~(|empty[gi-1:0]);
            end
            assign rr_onehot[gi] = (rr_reg == lg_els_p'(gi));
        end
    endgenerate

    assign full   = ~(|empty);
    assign target = full ? rr_onehot : empty_pick;
    assign rr     = rr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_reg <= '0;
        end else if (advance) begin
            rr_reg <= (rr_reg == lg_els_p'(els_p - 1)) ? '0 : rr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/bsg_cam_1r1w_sync_unmanaged.sv
// Simple synchronous-read CAM: per-entry valid/tag/data, writes by one-hot select, registered lookup.
module bsg_cam_1r1w_sync_unmanaged #(
    parameter int els_p        = 4,
    parameter int tag_width_p  = 8,
    parameter int data_width_p = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [els_p-1:0]        w_v,
    input  logic                    w_set_not_clear,
    input  logic [tag_width_p-1:0]  w_tag,
    input  logic [data_width_p-1:0] w_data,
    output logic [els_p-1:0]        w_empty,
    input  logic                    r_v,
    input  logic [tag_width_p-1:0]  r_tag,
    output logic [data_width_p-1:0] r_data,
    output logic                    r_hit
);

    logic [els_p-1:0]        valid_reg;
    logic [tag_width_p-1:0]  tag_reg  [els_p];
    logic [data_width_p-1:0] data_reg [els_p];
    logic                    match_any;
    logic [data_width_p-1:0] match_data;
    logic                    r_hit_reg;
    logic [data_width_p-1:0] r_data_reg;

    assign w_empty = ~valid_reg;
    assign r_hit   = r_hit_reg;
    assign r_data  = r_data_reg;

    always_comb begin
        match_any  = 1'b0;
        match_data = '0;
        for (int i = 0; i < els_p; i++) begin
            if (valid_reg[i] && tag_reg[i] == r_tag) begin
                match_any  = 1'b1;
                match_data = match_data | data_reg[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg  <= '0;
            r_hit_reg  <= 1'b0;
            r_data_reg <= '0;
            for (int i = 0; i < els_p; i++) begin
                tag_reg[i]  <= '0;
                data_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < els_p; i++) begin
                if (w_v[i]) begin
                    valid_reg[i] <= w_set_not_clear;
                    tag_reg[i]   <= w_tag;
                    data_reg[i]  <= w_data;
                end
            end
            r_hit_reg  <= r_v & match_any;
            r_data_reg <= r_v ? match_data : '0;
        end
    end

endmodule

// File: rtl/bsg_cam_1r1w_alloc_ctrl.sv
// CAM allocation controller: keeps a shadow copy of valid/tag to steer inserts, evictions and invalidates,
// and sequences lookups through the CAM's one-cycle read.
module bsg_cam_1r1w_alloc_ctrl
    import bsg_cam_1r1w_alloc_pkg::*;
#(
    parameter int els_p        = 4,
    parameter int tag_width_p  = 8,
    parameter int data_width_p = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_v_i,
    output logic                    req_ready_o,
    input  logic [1:0]              req_op_i,
    input  logic [tag_width_p-1:0]  req_tag_i,
    input  logic [data_width_p-1:0] req_data_i,
    output logic                    resp_v_o,
    input  logic                    resp_yumi_i,
    output logic                    resp_hit_o,
    output logic [data_width_p-1:0] resp_data_o,
    output logic                    evict_v_o,
    output logic [tag_width_p-1:0]  evict_tag_o,
    output logic [els_p-1:0]        cam_w_v_o,
    output logic                    cam_w_set_not_clear_o,
    output logic [tag_width_p-1:0]  cam_w_tag_o,
    output logic [data_width_p-1:0] cam_w_data_o,
    input  logic [els_p-1:0]        cam_w_empty_i,
    output logic                    cam_r_v_o,
    output logic [tag_width_p-1:0]  cam_r_tag_o,
    input  logic                    cam_r_v_i,
    input  logic [data_width_p-1:0] cam_r_data_i
);

    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

    state_e                  state_reg;
    logic [els_p-1:0]        valid_reg;
    logic [tag_width_p-1:0]  tag_reg [els_p];
    logic                    resp_hit_reg;
    logic [data_width_p-1:0] resp_data_reg;

    op_e                     op;
    logic                    ready;
    logic                    fire;
    logic                    lookup_fire;
    logic                    insert_fire;
    logic                    inval_fire;
    logic [els_p-1:0]        hit;
    logic                    any_hit;
    logic [els_p-1:0]        victim_target;
    logic                    full;
    logic [lg_els_lp-1:0]    rr;
    logic                    replace;
    logic [els_p-1:0]        insert_sel;

    assign op          = op_e'(req_op_i);
    assign ready       = reset & (state_reg == ST_IDLE);
    assign fire        = req_v_i & ready;
    assign lookup_fire = fire & (op == OP_LOOKUP);
    assign insert_fire = fire & (op == OP_INSERT);
    assign inval_fire  = fire & (op == OP_INVALIDATE);

    genvar gi;
    generate
        for (gi = 0; gi < els_p; gi++) begin : g_hit
            assign hit[gi] = valid_reg[gi] & (tag_reg[gi] == req_tag_i);
        end
    endgenerate
    assign any_hit = |hit;

    // Replacement only when the tag is new and no entry is free; a tag hit rewrites in place.
    assign replace    = insert_fire & ~any_hit & full;
    assign insert_sel = any_hit ? hit : victim_target;

    bsg_cam_1r1w_alloc_victim #(
        .els_p    (els_p),
        .lg_els_p (lg_els_lp)
    ) u_victim (
        .clk     (clk),
        .reset   (reset),
        .empty   (cam_w_empty_i),
        .advance (replace),
        .target  (victim_target),
        .full    (full),
        .rr      (rr)
    );

    assign req_ready_o           = ready;
    assign cam_w_v_o             = insert_fire ? insert_sel : (inval_fire ? hit : '0);
    assign cam_w_set_not_clear_o = insert_fire;
    assign cam_w_tag_o           = reset ? req_tag_i : '0;
    assign cam_w_data_o          = reset ? req_data_i : '0;
    assign cam_r_v_o             = lookup_fire;
    assign cam_r_tag_o           = reset ? req_tag_i : '0;
    assign evict_v_o             = replace;
    assign evict_tag_o           = replace ? tag_reg[rr] : '0;
    assign resp_v_o              = (state_reg == ST_RESP);
    assign resp_hit_o            = resp_hit_reg;
    assign resp_data_o           = resp_data_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            resp_hit_reg  <= 1'b0;
            resp_data_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: if (lookup_fire) state_reg <= ST_RD;
                ST_RD: begin
                    resp_hit_reg  <= cam_r_v_i;
                    resp_data_reg <= cam_r_data_i;
                    state_reg     <= ST_RESP;
                end
                ST_RESP: if (resp_yumi_i) state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= '0;
            for (int i = 0; i < els_p; i++) begin
                tag_reg[i] <= '0;
            end
        end else if (insert_fire) begin
            for (int i = 0; i < els_p; i++) begin
                if (insert_sel[i]) begin
                    valid_reg[i] <= 1'b1;
                    tag_reg[i]   <= req_tag_i;
                end
            end
        end else if (inval_fire) begin
            valid_reg <= valid_reg & ~hit;
        end
    end

endmodule
